// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment patterns are active high, ordered {a,b,c,d,e,f,g}.
package sevenseg_pkg;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } scan_state_e;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Nibble to active-high segment pattern, 0-F.
   function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
      logic [6:0] pat;
      case (nibble)
         4'h0:    pat = 7'h7E;
         4'h1:    pat = 7'h30;
         4'h2:    pat = 7'h6D;
         4'h3:    pat = 7'h79;
         4'h4:    pat = 7'h33;
         4'h5:    pat = 7'h5B;
         4'h6:    pat = 7'h5F;
         4'h7:    pat = 7'h70;
         4'h8:    pat = 7'h7F;
         4'h9:    pat = 7'h7B;
         4'hA:    pat = 7'h77;
         4'hB:    pat = 7'h1F;
         4'hC:    pat = 7'h4E;
         4'hD:    pat = 7'h3D;
         4'hE:    pat = 7'h4F;
         4'hF:    pat = 7'h47;
         default: pat = 7'h00;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Free-running scan prescaler: one digit slot is 2**DIV_WIDTH clocks.
// tick_o marks the last cycle of a slot, blank_done_o the last ghost-blank cycle.
module seg_scan_tick #(
   parameter int DIV_WIDTH    = 11,
   parameter int BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick_o,
   output logic blank_done_o
);

   localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);

   logic [DIV_WIDTH-1:0] divider_q;
   logic [DIV_WIDTH-1:0] divider_d;

   assign divider_d    = divider_q + DIV_WIDTH'(1);
   assign tick_o       = (divider_q == {DIV_WIDTH{1'b1}});
   assign blank_done_o = (divider_q == BLANK_LAST);

   // Divider wraps naturally from all ones back to zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         divider_q <= '0;
      end else begin
         divider_q <= divider_d;
      end
   end

endmodule

// File: rtl/sevensegdecode.sv
// Nibble to active-high seven-segment decoder {a,b,c,d,e,f,g}.
module sevensegdecode
   import sevenseg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = seg_pattern(nibble_i);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment scanner with frame-coherent snapshot,
// ghost blanking and frame pulse. Optional SEVENSEG_LZ_BLANK_EN: leading-zero suppression.
module seven_seg_scanner
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_BITS   = 3,
   parameter int DIV_WIDTH    = 11,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_DIGITS*DIGIT_BITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]            dots,
   input  logic                             blank_all,
   output logic [7:0]                       sevenseg,
   output logic [NUM_DIGITS-1:0]            sevenseg_an,
   output logic                             frame_done
);

   localparam int                VW       = NUM_DIGITS * DIGIT_BITS;
   localparam int                IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic                  tick_s;
   logic                  blank_done_s;
   scan_state_e           state_q;
   logic [IDX_W-1:0]      idx_q;
   logic [VW-1:0]         snap_value_q;
   logic [NUM_DIGITS-1:0] snap_dots_q;
   logic                  frame_done_q;
   logic [7:0]            sevenseg_q;
   logic [7:0]            sevenseg_d;
   logic [NUM_DIGITS-1:0] sevenseg_an_q;
   logic [NUM_DIGITS-1:0] sevenseg_an_d;
   logic [DIGIT_BITS-1:0] cur_digit_s;
   logic                  cur_dot_s;
   logic                  cur_sup_s;
   logic [NUM_DIGITS-1:0] an_sel_s;
   logic [6:0]            seg_s;

   seg_scan_tick #(
      .DIV_WIDTH    (DIV_WIDTH),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_tick (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick_o       (tick_s),
      .blank_done_o (blank_done_s)
   );

   // Scan FSM; the snapshot is taken on the wrap tick so a whole frame is coherent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_BLANK;
         idx_q        <= '0;
         snap_value_q <= '0;
         snap_dots_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_BLANK: begin
               if (blank_done_s) begin
                  state_q <= S_DRIVE;
               end else begin
                  state_q <= S_BLANK;
               end
            end
            S_DRIVE: begin
               if (tick_s) begin
                  state_q <= S_BLANK;
                  if (idx_q == IDX_LAST) begin
                     idx_q        <= '0;
                     snap_value_q <= value;
                     snap_dots_q  <= dots;
                     frame_done_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  state_q <= S_DRIVE;
               end
            end
            default: begin
               state_q <= S_BLANK;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign cur_digit_s = DIGIT_BITS'(snap_value_q >> (DIGIT_BITS * int'(idx_q)));
   assign cur_dot_s   = snap_dots_q[idx_q];
   assign an_sel_s    = ~(NUM_DIGITS'(1) << idx_q);

   sevensegdecode u_dec (
      .nibble_i (4'(cur_digit_s)),
      .seg_o    (seg_s)
   );

`ifdef SEVENSEG_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] zero_from_s;

   // zero_from_s[i]: digits i..NUM_DIGITS-1 of the snapshot are all zero.
   always_comb begin
      zero_from_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         zero_from_s[i] = ((snap_value_q >> (i * DIGIT_BITS)) == '0);
      end
   end

   assign cur_sup_s = (idx_q != '0) && zero_from_s[idx_q];
`else
   assign cur_sup_s = 1'b0;
`endif

   // Next output image; a suppressed digit keeps its anode only to show a lit dot.
   always_comb begin
      sevenseg_d    = SEG_OFF;
      sevenseg_an_d = '1;
      if ((state_q == S_DRIVE) && !blank_all) begin
         if (!cur_sup_s) begin
            sevenseg_an_d = an_sel_s;
            sevenseg_d    = {~seg_s, ~cur_dot_s};
         end else if (cur_dot_s) begin
            sevenseg_an_d = an_sel_s;
            sevenseg_d    = {7'h7F, 1'b0};
         end else begin
            sevenseg_an_d = '1;
            sevenseg_d    = SEG_OFF;
         end
      end else begin
         sevenseg_an_d = '1;
         sevenseg_d    = SEG_OFF;
      end
   end

   // Output registers lag the state/index by one clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sevenseg_q    <= SEG_OFF;
         sevenseg_an_q <= '1;
      end else begin
         sevenseg_q    <= sevenseg_d;
         sevenseg_an_q <= sevenseg_an_d;
      end
   end

   assign sevenseg    = sevenseg_q;
   assign sevenseg_an = sevenseg_an_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 octal digits, 8-cycle slots, 2 blank cycles).
// Reference model derives the expected display from the edge count since reset.
module tb_seven_seg_scanner;

   logic        clk;
   logic        reset_n;
   logic [11:0] value;
   logic [3:0]  dots;
   logic        blank_all;
   logic [7:0]  sevenseg;
   logic [3:0]  sevenseg_an;
   logic        frame_done;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   seven_seg_scanner #(
      .NUM_DIGITS   (4),
      .DIGIT_BITS   (3),
      .DIV_WIDTH    (3),
      .BLANK_CYCLES (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .value       (value),
      .dots        (dots),
      .blank_all   (blank_all),
      .sevenseg    (sevenseg),
      .sevenseg_an (sevenseg_an),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Segment shapes {a,b,c,d,e,f,g} for octal digits.
   function automatic logic [6:0] shape(input int n);
      case (n)
         0:       return 7'b1111110;
         1:       return 7'b0110000;
         2:       return 7'b1101101;
         3:       return 7'b1111001;
         4:       return 7'b0110011;
         5:       return 7'b1011011;
         6:       return 7'b1011111;
         7:       return 7'b1110000;
         default: return 7'b0000000;
      endcase
   endfunction

   // Display after the state of edge count k: slot = k/8, digit = slot mod 4, lit from phase 2.
   function automatic logic [11:0] model_out(input int k, input logic [11:0] sv,
                                             input logic [3:0] sd, input logic blk);
      logic [3:0] an;
      logic [7:0] seg;
      int         d;
      int         digit;
      logic       sup;
      an    = 4'hF;
      seg   = 8'hFF;
      d     = (k / 8) % 4;
      digit = int'((sv >> (3 * d)) & 12'd7);
      sup   = 1'b0;
`ifdef SEVENSEG_LZ_BLANK_EN
      sup   = (d > 0) && ((sv >> (3 * d)) == 12'd0);
`endif
      if ((k % 8) >= 2 && !blk) begin
         if (!sup) begin
            an[d] = 1'b0;
            seg   = {~shape(digit), ~sd[d]};
         end else if (sd[d]) begin
            an[d] = 1'b0;
            seg   = 8'hFE;
         end
      end
      return {an, seg};
   endfunction

   int          m_k;
   logic [11:0] m_snap_v;
   logic [3:0]  m_snap_d;
   logic [11:0] m_out;
   logic        m_fd;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_k      <= 0;
         m_snap_v <= 12'd0;
         m_snap_d <= 4'd0;
         m_out    <= 12'hFFF;
         m_fd     <= 1'b0;
      end else begin
         m_k   <= m_k + 1;
         m_out <= model_out(m_k, m_snap_v, m_snap_d, blank_all);
         m_fd  <= ((m_k + 1) % 32 == 0);
         if ((m_k + 1) % 32 == 0) begin
            m_snap_v <= value;
            m_snap_d <= dots;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("an_model", 32'(sevenseg_an), 32'(m_out[11:8]));
         chk("seg_model", 32'(sevenseg), 32'(m_out[7:0]));
         chk("fd_model", 32'(frame_done), 32'(m_fd));
      end
   endtask

   task automatic wait_fd();
      int n;
      n = 0;
      while (n < 64 && frame_done !== 1'b1) begin
         run(1);
         n++;
      end
      chk("frame_done_timeout", 32'(frame_done), 32'd1);
   endtask

   // Checks one frame starting right after a frame_done sample, 3 cycles into each slot.
   task automatic check_frame(input string tag, input logic [3:0] e_an[4], input logic [7:0] e_seg[4]);
      run(3);
      for (int s = 0; s < 4; s++) begin
         chk({tag, "_an"}, 32'(sevenseg_an), 32'(e_an[s]));
         chk({tag, "_seg"}, 32'(sevenseg), 32'(e_seg[s]));
         if (s < 3) run(8);
      end
   endtask

   initial begin
      logic [3:0] an_cyc[4];
      logic [7:0] seg_exp[4];
      int         n;
      an_cyc = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      // 1. Reset
      reset_n   = 1'b0;
      value     = 12'o1234;
      dots      = 4'b0000;
      blank_all = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_an", 32'(sevenseg_an), 32'hF);
      chk("reset_seg", 32'(sevenseg), 32'hFF);
      chk("reset_fd", 32'(frame_done), 32'd0);
      reset_n = 1'b1;
      n = 0;
      while (n < 16 && sevenseg_an === 4'hF) begin
         run(1);
         n++;
      end
      chk("first_drive_an", 32'(sevenseg_an), 32'hE);
      chk("first_drive_seg", 32'(sevenseg), 32'h03);

      // 2. Scan 4,3,2,1 across digits 0..3
      wait_fd();
      seg_exp = '{8'h99, 8'h0D, 8'h25, 8'h9F};
      check_frame("scan", an_cyc, seg_exp);

      // 3. Coherence: change value while digit 1 is driven
      wait_fd();
      run(3 + 8);
      chk("coh_d1_an", 32'(sevenseg_an), 32'hD);
      value = 12'o7777;
      run(8);
      chk("coh_d2_seg", 32'(sevenseg), 32'h25);
      run(8);
      chk("coh_d3_seg", 32'(sevenseg), 32'h9F);
      wait_fd();
      seg_exp = '{8'h1F, 8'h1F, 8'h1F, 8'h1F};
      check_frame("coh_next", an_cyc, seg_exp);

      // 4. Global blank for 40 cycles
      blank_all = 1'b1;
      for (int i = 0; i < 40; i++) begin
         run(1);
         chk("blank_an", 32'(sevenseg_an), 32'hF);
      end
      blank_all = 1'b0;
      run(20);

      // 5. Dots on digits 0 and 2
      value = 12'o1234;
      dots  = 4'b0101;
      wait_fd();
      seg_exp = '{8'h98, 8'h0D, 8'h24, 8'h9F};
      check_frame("dots", an_cyc, seg_exp);

      // 6. Leading zeros
      value = 12'o0050;
      dots  = 4'b0000;
      wait_fd();
`ifdef SEVENSEG_LZ_BLANK_EN
      an_cyc  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
      seg_exp = '{8'h03, 8'h49, 8'hFF, 8'hFF};
`else
      seg_exp = '{8'h03, 8'h49, 8'h03, 8'h03};
`endif
      check_frame("lz", an_cyc, seg_exp);

      // Random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         run(1);
         if ($urandom_range(0, 9) == 0) value = 12'($urandom);
         if ($urandom_range(0, 9) == 0) dots = 4'($urandom);
         if ($urandom_range(0, 15) == 0) blank_all = ~blank_all;
         if (i % 50 == 7 && $urandom_range(0, 1) == 1) value = 12'($urandom_range(0, 7));
      end

      // Asynchronous reset in mid-slot, then restart at digit 0
      run(13);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_an", 32'(sevenseg_an), 32'hF);
      chk("midreset_seg", 32'(sevenseg), 32'hFF);
      chk("midreset_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      blank_all = 1'b0;
      value     = 12'o0123;
      dots      = 4'b0000;
      reset_n   = 1'b1;
      run(3);
      chk("restart_an", 32'(sevenseg_an), 32'hE);
      chk("restart_seg", 32'(sevenseg), 32'h03);
      run(100);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
